// File: rtl/jtpopeye_sec_bridge_if.sv
// Bus bundle between the Z80 I/O side and the protection shifter.
// The master side drives the CPU bus and the shifter result; the bridge is the slave.
interface jtpopeye_sec_bridge_if;
  logic       iorq_n;
  logic       m1_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] addr;
  logic [7:0] cpu_dout;
  logic [7:0] cpu_din;
  logic       wait_n;
  logic       sec_cs;
  logic       sec_A0;
  logic       sec_rd_n;
  logic       sec_wr_n;
  logic [7:0] sec_din;
  logic [7:0] sec_dout;

  modport master (
    output iorq_n, m1_n, rd_n, wr_n, addr, cpu_dout, sec_dout,
    input  cpu_din, wait_n, sec_cs, sec_A0, sec_rd_n, sec_wr_n, sec_din
  );

  modport slave (
    input  iorq_n, m1_n, rd_n, wr_n, addr, cpu_dout, sec_dout,
    output cpu_din, wait_n, sec_cs, sec_A0, sec_rd_n, sec_wr_n, sec_din
  );
endinterface

// File: rtl/jtpopeye_sec_bridge.sv
// Z80 I/O front end for the protection shifter: one cen-aligned write strobe per
// OUT cycle, and IN cycles stretched with wait_n until the shifter result is captured.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight, watching for a window hit
// WR_PEND | write strobe asserted, waiting for the cen that commits it
// WR_DONE | write committed, waiting for the CPU bus cycle to end
// RD_WAIT | read strobe asserted, CPU held, counting cen pulses
// RD_CAP  | one clk: capture the shifter byte and release wait_n
// RD_HOLD | data presented, waiting for the CPU bus cycle to end
module jtpopeye_sec_bridge #(
  parameter logic [7:0] PORT   = 8'h02,
  parameter int         RD_CEN = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cen,
  jtpopeye_sec_bridge_if.slave         bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_PEND,
    WR_DONE,
    RD_WAIT,
    RD_CAP,
    RD_HOLD
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(RD_CEN - 1);

  state_t     state;
  logic [1:0] cen_cnt;
  logic       hit;
  logic       wr_end;
  logic       rd_end;

  // Int-ack cycles (m1_n low) share iorq_n with I/O cycles and must never decode.
  assign hit    = !bus.iorq_n && bus.m1_n && (bus.addr[7:1] == PORT[7:1]);
  assign wr_end = bus.wr_n || bus.iorq_n;
  assign rd_end = bus.rd_n || bus.iorq_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cen_cnt      <= 2'd0;
      bus.wait_n   <= 1'b1;
      bus.sec_cs   <= 1'b0;
      bus.sec_rd_n <= 1'b1;
      bus.sec_wr_n <= 1'b1;
      bus.sec_A0   <= 1'b0;
      bus.sec_din  <= 8'h00;
      bus.cpu_din  <= 8'hFF;
    end else begin
      case (state)
        IDLE: begin
          if (hit && !bus.wr_n) begin
            bus.sec_A0   <= bus.addr[0];
            bus.sec_din  <= bus.cpu_dout;
            bus.sec_cs   <= 1'b1;
            bus.sec_wr_n <= 1'b0;
            state        <= WR_PEND;
          end else if (hit && !bus.rd_n) begin
            bus.sec_A0   <= bus.addr[0];
            cen_cnt      <= 2'd0;
            bus.sec_cs   <= 1'b1;
            bus.sec_rd_n <= 1'b0;
            bus.wait_n   <= 1'b0;
            state        <= RD_WAIT;
          end
        end
        // The write commits on the next cen even if the CPU already left the cycle.
        WR_PEND: begin
          if (cen) begin
            bus.sec_cs   <= 1'b0;
            bus.sec_wr_n <= 1'b1;
            state        <= WR_DONE;
          end
        end
        WR_DONE: begin
          if (wr_end) state <= IDLE;
        end
        RD_WAIT: begin
          if (rd_end) begin
            bus.sec_cs   <= 1'b0;
            bus.sec_rd_n <= 1'b1;
            bus.wait_n   <= 1'b1;
            state        <= IDLE;
          end else if (cen) begin
            if (cen_cnt == CNT_LAST) state <= RD_CAP;
            else cen_cnt <= cen_cnt + 2'd1;
          end
        end
        RD_CAP: begin
          bus.cpu_din  <= bus.sec_dout;
          bus.wait_n   <= 1'b1;
          bus.sec_cs   <= 1'b0;
          bus.sec_rd_n <= 1'b1;
          state        <= RD_HOLD;
        end
        RD_HOLD: begin
          if (rd_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_sec_bridge.sv
// Bench for jtpopeye_sec_bridge: directed vector table, hand-written corner sequences
// and random bus traffic, against a transaction-level shifter model.
module tb_jtpopeye_sec_bridge;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen   = 1'b0;
  int         cen_mode = 2;      // 0 off, 1 every 4th clk, 2 always, 3 random
  logic [1:0] cen_div  = 2'd0;
  int         cen_gap  = 0;

  int total = 0;
  int bad   = 0;

  localparam int RDC1 = 1;

  jtpopeye_sec_bridge_if bus ();
  jtpopeye_sec_bridge_if bus2 ();

  jtpopeye_sec_bridge #(.PORT(8'h02), .RD_CEN(RDC1)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus)
  );

  jtpopeye_sec_bridge #(.PORT(8'h02), .RD_CEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus2)
  );

  assign bus2.iorq_n   = bus.iorq_n;
  assign bus2.m1_n     = bus.m1_n;
  assign bus2.rd_n     = bus.rd_n;
  assign bus2.wr_n     = bus.wr_n;
  assign bus2.addr     = bus.addr;
  assign bus2.cpu_dout = bus.cpu_dout;
  assign bus2.sec_dout = 8'h3C;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bit nxt;
    #1;
    case (cen_mode)
      0:       nxt = 1'b0;
      1:       nxt = (cen_div == 2'd3);
      2:       nxt = 1'b1;
      default: nxt = ($urandom_range(0, 1) == 1) || (cen_gap >= 3);
    endcase
    cen_div <= cen_div + 2'd1;
    cen_gap <= nxt ? 0 : cen_gap + 1;
    cen     <= nxt;
  end

  // Shifter: A0=1 writes set the shift, A0=0 writes push a byte; result is the
  // upper byte of the 16-bit {older,newer} pair shifted left.
  function automatic logic [7:0] shf(input logic [7:0] hi, input logic [7:0] lo,
                                     input logic [2:0] sh);
    logic [23:0] w;
    w = {8'h00, hi, lo} << sh;
    return w[15:8];
  endfunction

  logic [7:0] s_hi = 8'h00;
  logic [7:0] s_lo = 8'h00;
  logic [2:0] s_sh = 3'd0;

  always @(posedge clk) begin
    if (bus.sec_cs && !bus.sec_wr_n && cen) begin
      if (bus.sec_A0) s_sh <= bus.sec_din[2:0];
      else begin
        s_hi <= s_lo;
        s_lo <= bus.sec_din;
      end
    end
  end
  assign bus.sec_dout = shf(s_hi, s_lo, s_sh);

  // Transaction-level expectation of the shifter contents.
  logic [7:0] m_hi = 8'h00;
  logic [7:0] m_lo = 8'h00;
  logic [2:0] m_sh = 3'd0;
  logic [7:0] exp_din = 8'hFF;

  int         strobe_cnt = 0;
  int         act_cnt    = 0;
  int         wl_cnt     = 0;
  logic       st_a0      = 1'b0;
  logic [7:0] st_din     = 8'h00;

  always @(negedge clk) begin
    if (bus.sec_cs && !bus.sec_wr_n && cen) begin
      strobe_cnt <= strobe_cnt + 1;
      st_a0      <= bus.sec_A0;
      st_din     <= bus.sec_din;
    end
    if (bus.sec_cs || !bus.sec_wr_n || !bus.sec_rd_n) act_cnt <= act_cnt + 1;
    if (!bus.wait_n) wl_cnt <= wl_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.iorq_n = 1'b1;
    bus.m1_n   = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a[0]) m_sh = d[2:0];
    else begin
      m_hi = m_lo;
      m_lo = d;
    end
  endtask

  // kind: 0 OUT, 1 IN, 2 int-ack, 3 OUT with rd_n also low
  task automatic run_txn(input int kind, input logic [7:0] a, input logic [7:0] d,
                         input int hold, input bit hit, input logic [7:0] exp_rd,
                         input string tag);
    int  s_st, s_act, s_wl, low, ncen, exp_low;
    bit  done;
    s_st  = strobe_cnt;
    s_act = act_cnt;
    s_wl  = wl_cnt;
    bus.addr     = a;
    bus.cpu_dout = d;
    bus.iorq_n   = 1'b0;
    bus.m1_n     = (kind == 2) ? 1'b0 : 1'b1;
    bus.wr_n     = (kind == 0 || kind == 3) ? 1'b0 : 1'b1;
    bus.rd_n     = (kind == 1 || kind == 3) ? 1'b0 : 1'b1;
    if (kind == 1 && hit) begin
      low = 0; ncen = 0; exp_low = -1; done = 1'b0;
      // wait_n should stay low until the clk after the RDC1-th cen seen in RD_WAIT
      for (int j = 1; j <= 60 && !done; j++) begin
        tick();
        if (!bus.wait_n) low++;
        else if (j > 1) done = 1'b1;
        if (!done && cen && ncen < RDC1) begin
          ncen++;
          if (ncen == RDC1) exp_low = j + 1;
        end
      end
      check({tag, " wait released"}, 32'(done), 32'd1);
      check({tag, " wait clks"}, low, exp_low);
      check({tag, " rdata"}, bus.cpu_din, exp_rd);
      exp_din = exp_rd;
      repeat (hold) tick();
      check({tag, " rdata hold"}, bus.cpu_din, exp_rd);
      bus_idle();
      tick();
      tick();
    end else begin
      repeat (hold) tick();
      bus_idle();
      repeat (8) tick();
      if (hit) begin
        check({tag, " strobes"}, strobe_cnt - s_st, 1);
        check({tag, " A0"}, st_a0, a[0]);
        check({tag, " din"}, st_din, d);
        check({tag, " no wait"}, wl_cnt - s_wl, 0);
        model_write(a, d);
      end else begin
        check({tag, " no sec activity"}, act_cnt - s_act, 0);
        check({tag, " no wait"}, wl_cnt - s_wl, 0);
      end
    end
  endtask

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         hold;
    bit         hit;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low1, low2;
    vecs[0]  = '{0, 8'h03, 8'h05, 20, 1'b1, 8'h00};
    vecs[1]  = '{0, 8'h02, 8'hAA,  3, 1'b1, 8'h00};
    vecs[2]  = '{0, 8'h02, 8'h55,  3, 1'b1, 8'h00};
    vecs[3]  = '{0, 8'h03, 8'h03,  3, 1'b1, 8'h00};
    vecs[4]  = '{1, 8'h02, 8'h00,  2, 1'b1, 8'h52};
    vecs[5]  = '{1, 8'h04, 8'h00,  4, 1'b0, 8'h00};
    vecs[6]  = '{0, 8'h04, 8'h77,  4, 1'b0, 8'h00};
    vecs[7]  = '{2, 8'h02, 8'h00,  4, 1'b0, 8'h00};
    vecs[8]  = '{0, 8'h02, 8'hC3,  1, 1'b1, 8'h00};
    vecs[9]  = '{1, 8'h03, 8'h00,  1, 1'b1, 8'hAE};
    vecs[10] = '{3, 8'h02, 8'h3C,  3, 1'b1, 8'h00};
    vecs[11] = '{1, 8'h02, 8'h00,  2, 1'b1, 8'h19};

    bus_idle();
    bus.addr     = 8'h00;
    bus.cpu_dout = 8'h00;
    rst_n        = 1'b0;
    repeat (3) tick();
    check("reset wait_n", bus.wait_n, 1'b1);
    check("reset sec_cs", bus.sec_cs, 1'b0);
    check("reset sec_wr_n", bus.sec_wr_n, 1'b1);
    check("reset sec_rd_n", bus.sec_rd_n, 1'b1);
    check("reset sec_A0", bus.sec_A0, 1'b0);
    check("reset sec_din", bus.sec_din, 8'h00);
    check("reset cpu_din", bus.cpu_din, 8'hFF);
    rst_n = 1'b1;
    tick();

    cen_mode = 1;
    tick();
    foreach (vecs[i])
      run_txn(vecs[i].kind, vecs[i].addr, vecs[i].data, vecs[i].hold, vecs[i].hit,
              vecs[i].rd, $sformatf("vec%0d", i));

    // Read abandoned by the CPU before any cen: no capture.
    cen_mode = 0;
    tick();
    bus.addr = 8'h02; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    repeat (3) tick();
    check("abort wait low", bus.wait_n, 1'b0);
    bus_idle();
    tick();
    check("abort wait_n", bus.wait_n, 1'b1);
    check("abort sec_cs", bus.sec_cs, 1'b0);
    check("abort sec_rd_n", bus.sec_rd_n, 1'b1);
    check("abort cpu_din kept", bus.cpu_din, exp_din);
    tick();

    // Async reset while in RD_WAIT.
    bus.addr = 8'h02; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    repeat (2) tick();
    check("rdwait wait low", bus.wait_n, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst rd wait_n", bus.wait_n, 1'b1);
    check("rst rd sec_cs", bus.sec_cs, 1'b0);
    check("rst rd sec_rd_n", bus.sec_rd_n, 1'b1);
    check("rst rd cpu_din", bus.cpu_din, 8'hFF);
    bus_idle();
    tick();
    rst_n = 1'b1;
    tick();
    exp_din  = 8'hFF;
    cen_mode = 1;
    tick();
    run_txn(1, 8'h02, 8'h00, 1, 1'b1, shf(m_hi, m_lo, m_sh), "post-reset read");

    // Async reset while in WR_PEND: write is dropped.
    cen_mode = 0;
    tick();
    begin
      int s_st;
      s_st = strobe_cnt;
      bus.addr = 8'h02; bus.cpu_dout = 8'h99; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
      repeat (2) tick();
      check("wrpend strobe low", bus.sec_wr_n, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst wr sec_wr_n", bus.sec_wr_n, 1'b1);
      check("rst wr sec_cs", bus.sec_cs, 1'b0);
      bus_idle();
      tick();
      rst_n = 1'b1;
      cen_mode = 1;
      repeat (8) tick();
      check("rst wr dropped", strobe_cnt - s_st, 0);
    end
    run_txn(1, 8'h02, 8'h00, 1, 1'b1, shf(m_hi, m_lo, m_sh), "post-reset read2");

    // cen tied high: RD_CEN=2 instance latencies.
    cen_mode = 2;
    repeat (2) tick();
    bus.addr = 8'h03; bus.cpu_dout = 8'h02; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    tick();
    check("cen hi wr strobe", {29'd0, bus2.sec_cs, bus2.sec_wr_n, cen}, 32'b101);
    tick();
    check("cen hi wr single", bus2.sec_wr_n, 1'b1);
    bus_idle();
    repeat (2) tick();
    model_write(8'h03, 8'h02);
    bus.addr = 8'h02; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    low1 = 0; low2 = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (!bus.wait_n) low1++;
      if (!bus2.wait_n) low2++;
    end
    check("cen hi rd_cen2 wait clks", low2, 3);
    check("cen hi rd_cen1 wait clks", low1, 2);
    check("cen hi rd_cen2 data", bus2.cpu_din, 8'h3C);
    check("cen hi rd_cen1 data", bus.cpu_din, shf(m_hi, m_lo, m_sh));
    exp_din = shf(m_hi, m_lo, m_sh);
    bus_idle();
    repeat (2) tick();

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      int         r, kind, hold;
      logic [7:0] a, d;
      cen_mode = $urandom_range(1, 3);
      tick();
      r    = $urandom_range(0, 4);
      d    = 8'($urandom_range(0, 255));
      hold = $urandom_range(1, 5);
      if (r <= 2) begin
        a    = {7'h01, 1'($urandom_range(0, 1))};
        kind = (r == 2) ? 1 : 0;
        run_txn(kind, a, d, hold, 1'b1, shf(m_hi, m_lo, m_sh), $sformatf("rnd%0d", n));
      end else begin
        a = 8'($urandom_range(0, 255));
        if (r == 4) begin
          a[7:1] = 7'h01;
          kind   = 2;
        end else begin
          if (a[7:1] == 7'h01) a[7] = 1'b1;
          kind = $urandom_range(0, 1);
        end
        run_txn(kind, a, d, hold, 1'b0, 8'h00, $sformatf("rnd%0d", n));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
